// File: rtl/data_mem_controller.sv
// Data-memory controller: turns memory-stage load/store requests into a single
// word-wide req/ack bus access with lane steering, load extension and timeout.
module data_mem_controller #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] memory_addr,
  input  logic [31:0] data_to_write,
  input  logic [2:0]  funct3,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            mis_q, mis_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  function automatic logic req_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = !is_store;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic req_aligned(input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    ok = 1'b1;
    case (f3[1:0])
      2'b01:   ok = !off[0];
      2'b10:   ok = (off == 2'b00);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] steer(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    w = d;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Shift the addressed lane down to bit 0, then sign/zero extend by funct3.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [31:0] s;
    logic [31:0] r;
    s = word >> {off, 3'b000};
    r = s;
    case (f3)
      3'b000:  r = {{24{s[7]}}, s[7:0]};
      3'b001:  r = {{16{s[15]}}, s[15:0]};
      3'b100:  r = {24'h000000, s[7:0]};
      3'b101:  r = {16'h0000, s[15:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  // Next-state and datapath update for the access FSM.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (read || write) begin
          if (req_legal(write, funct3) && req_aligned(funct3, memory_addr[1:0])) begin
            state_d = BUS;
            req_d   = 1'b1;
            we_d    = write;
            addr_d  = {memory_addr[31:2], 2'b00};
            be_d    = byte_en(funct3, memory_addr[1:0]);
            wdata_d = write ? steer(funct3, data_to_write) : 32'h0000_0000;
            f3_d    = funct3;
            off_d   = memory_addr[1:0];
            cnt_d   = {CW{1'b0}};
          end else begin
            state_d = DONE;
            mis_d   = 1'b1;
            rdata_d = 32'h0000_0000;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUS: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (bus_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = 32'h0000_0000;
          be_d    = 4'b0000;
          wdata_d = 32'h0000_0000;
          if (!we_q) begin
            rdata_d = load_ext(f3_q, off_q, bus_rdata);
          end else begin
            rdata_d = rdata_q;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = 32'h0000_0000;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = 32'h0000_0000;
          be_d    = 4'b0000;
          wdata_d = 32'h0000_0000;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0000_0000;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0000_0000;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      rdata_q <= 32'h0000_0000;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall      = ((state_q == IDLE) && (read || write)) || (state_q == BUS);
  assign read_data  = rdata_q;
  assign misaligned = mis_q;
  assign bus_err    = err_q;
  assign bus_req    = req_q;
  assign bus_we     = we_q;
  assign bus_addr   = addr_q;
  assign bus_be     = be_q;
  assign bus_wdata  = wdata_q;

endmodule
